prog_launcher: RTL
==================

PROG_LAUNCHER -- requirements
Module: prog_launcher

Interface
REQ-001 Parameter RESULT_ADDR, default 8, is the data-memory address read back after the core finishes.
REQ-002 Parameter RST_CYCLES, default 2, is the number of cycles CoreReset is held high.
REQ-003 Parameter TIMEOUT, default 1024, is the maximum number of RUN cycles allowed before abort.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high launcher reset.
REQ-006 Go  input  1  host request; level, sampled in IDLE.
REQ-007 Ack  input  1  core done flag from processor TopLevel.
REQ-008 DmRdData  input  8  data-memory read data, combinational from DmAddr.
REQ-009 CoreReset  output  1  drives processor Reset.
REQ-010 Start  output  1  drives processor Start; high = core parked, falling to low = launch.
REQ-011 DmWrEn  output  1  data-memory write enable.
REQ-012 DmAddr  output  8  data-memory address.
REQ-013 DmWrData  output  8  data-memory write data; always 0x00.
REQ-014 Done  output  1  sequence finished; level.
REQ-015 Result  output  8  byte captured from RESULT_ADDR.
REQ-016 TimedOut  output  1  run aborted by watchdog.

Function
REQ-017 FSM states SHALL be IDLE, CORE_RST, CLEAR, RUN, READBACK, DONE; all outputs registered.
REQ-018 IDLE: Start=1, CoreReset=0, DmWrEn=0; Go=1 -> CORE_RST next cycle, clears Done, TimedOut, and Result.
REQ-019 CORE_RST: CoreReset=1, Start=1 for exactly RST_CYCLES cycles, then CLEAR.
REQ-020 CLEAR: DmWrEn=1, DmWrData=0x00, DmAddr steps 0x00..0xFF, one address per cycle (256 cycles), Start=1, then RUN.
REQ-021 Address counter SHALL be 8-bit; the wrap from 0xFF to 0x00 terminates CLEAR, with no 257th write.
REQ-022 RUN: Start=0 and DmWrEn=0; DmAddr=RESULT_ADDR; Ack=1 in any RUN cycle, including the first, -> READBACK.
REQ-023 READBACK: one cycle; Result <= DmRdData at RESULT_ADDR; Start returns to 1; next state DONE.
REQ-024 DONE: Done=1; remains in DONE while Go=1; Go=0 -> IDLE, with Done cleared on entry to IDLE.
REQ-025 Go changes outside IDLE and DONE SHALL be ignored; Ack outside RUN SHALL be ignored.
REQ-026 Go-to-launch latency (Start falling) SHALL be exactly 1+RST_CYCLES+256 cycles.
REQ-027 Ack-to-Done latency SHALL be 2 cycles.

Reset
REQ-028 Reset=1 at a rising edge SHALL force IDLE from any state, including mid-CLEAR and mid-RUN.
REQ-029 Reset values: CoreReset=0, Start=1, DmWrEn=0, DmAddr=0x00, DmWrData=0x00, Done=0, Result=0x00, TimedOut=0, counters=0.
REQ-030 Reset during CLEAR SHALL deassert DmWrEn in the following cycle; a partial clear is not resumed.

Configuration
REQ-031 Macro LAUNCH_TIMEOUT_EN defined: a 16-bit RUN-cycle counter SHALL run, and reaching TIMEOUT cycles without Ack -> DONE with TimedOut=1, Result unchanged (0x00), Start=1.
REQ-032 Macro LAUNCH_TIMEOUT_EN undefined: no counter; RUN waits indefinitely; TimedOut is tied to 0.
REQ-033 Ack and timeout in the same cycle: Ack wins, so READBACK executes and TimedOut=0.

Verification
REQ-034 Reset 2 cycles, Go=1 -> CoreReset high 2 cycles, 256 writes of 0x00 to addresses 0..255, Start falls at cycle 259.
REQ-035 Model core writes 0x2A to addr 8 then asserts Ack at RUN cycle 15 -> Result=0x2A, Done=1 two cycles after Ack, TimedOut=0.
REQ-036 With LAUNCH_TIMEOUT_EN and TIMEOUT=1024, Ack never asserted -> TimedOut=1 and Done=1 after 1024 RUN cycles, Result=0x00.
REQ-037 Reset asserted at CLEAR address 0x80 -> IDLE next cycle, DmWrEn=0, Start=1, no further writes.
REQ-038 Ack held high in RUN cycle 0 -> READBACK immediately; Go held high in DONE for 10 cycles -> Done stays 1; Go=0 -> IDLE.
REQ-039 Ack pulsed during CLEAR -> ignored, RUN still entered and waits for a fresh Ack.

Source files
------------

// File: rtl/prog_launcher.sv
// Program launcher: resets the core, zero-fills data memory, releases the core,
// then reads back one result byte. Optional watchdog enabled by LAUNCH_TIMEOUT_EN.
module prog_launcher #(
  parameter int unsigned RESULT_ADDR = 8,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Go,
  input  logic       Ack,
  input  logic [7:0] DmRdData,
  output logic       CoreReset,
  output logic       Start,
  output logic       DmWrEn,
  output logic [7:0] DmAddr,
  output logic [7:0] DmWrData,
  output logic       Done,
  output logic [7:0] Result,
  output logic       TimedOut
);

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned TCW = 16;

  if (RST_CYCLES == 0 || TIMEOUT == 0 || TIMEOUT > 65536) begin : g_param_check
    $error("prog_launcher: RST_CYCLES must be >= 1 and TIMEOUT in 1..65536");
  end

  typedef enum logic [2:0] {
    IDLE,
    CORE_RST,
    CLEAR,
    RUN,
    READBACK,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            core_reset_q, core_reset_d;
  logic            start_q, start_d;
  logic            wr_en_q, wr_en_d;
  logic            done_q, done_d;
  logic [DW-1:0]   result_q, result_d;
  logic [AW:0]     addr_inc;

`ifdef LAUNCH_TIMEOUT_EN
  logic [TCW-1:0]  run_cnt_q, run_cnt_d;
  logic            timed_out_q, timed_out_d;
`endif

  // Carry out of the 8-bit address counter marks the end of the clear sweep
  assign addr_inc = {1'b0, addr_q} + (AW+1)'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    addr_d       = addr_q;
    core_reset_d = core_reset_q;
    start_d      = start_q;
    wr_en_d      = wr_en_q;
    done_d       = done_q;
    result_d     = result_q;
`ifdef LAUNCH_TIMEOUT_EN
    run_cnt_d    = run_cnt_q;
    timed_out_d  = timed_out_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Go) begin
          state_d      = CORE_RST;
          rst_cnt_d    = '0;
          core_reset_d = 1'b1;
          start_d      = 1'b1;
          done_d       = 1'b0;
          result_d     = '0;
`ifdef LAUNCH_TIMEOUT_EN
          timed_out_d  = 1'b0;
`endif
        end
      end
      CORE_RST: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d      = CLEAR;
          core_reset_d = 1'b0;
          wr_en_d      = 1'b1;
          addr_d       = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      CLEAR: begin
        if (addr_inc[AW]) begin
          state_d = RUN;
          wr_en_d = 1'b0;
          addr_d  = AW'(RESULT_ADDR);
          start_d = 1'b0;
`ifdef LAUNCH_TIMEOUT_EN
          run_cnt_d = '0;
`endif
        end else begin
          addr_d = addr_inc[AW-1:0];
        end
      end
      RUN: begin
        // Ack takes priority over a watchdog expiry in the same cycle
        if (Ack) begin
          state_d = READBACK;
          start_d = 1'b1;
        end
`ifdef LAUNCH_TIMEOUT_EN
        else if (run_cnt_q == TCW'(TIMEOUT - 1)) begin
          state_d     = DONE;
          start_d     = 1'b1;
          done_d      = 1'b1;
          timed_out_d = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + TCW'(1);
        end
`endif
      end
      READBACK: begin
        state_d  = DONE;
        result_d = DmRdData;
        done_d   = 1'b1;
      end
      DONE: begin
        if (!Go) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      rst_cnt_q    <= '0;
      addr_q       <= '0;
      core_reset_q <= 1'b0;
      start_q      <= 1'b1;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
`ifdef LAUNCH_TIMEOUT_EN
      run_cnt_q    <= '0;
      timed_out_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      addr_q       <= addr_d;
      core_reset_q <= core_reset_d;
      start_q      <= start_d;
      wr_en_q      <= wr_en_d;
      done_q       <= done_d;
      result_q     <= result_d;
`ifdef LAUNCH_TIMEOUT_EN
      run_cnt_q    <= run_cnt_d;
      timed_out_q  <= timed_out_d;
`endif
    end
  end

  assign CoreReset = core_reset_q;
  assign Start     = start_q;
  assign DmWrEn    = wr_en_q;
  assign DmAddr    = addr_q;
  assign DmWrData  = '0;
  assign Done      = done_q;
  assign Result    = result_q;
`ifdef LAUNCH_TIMEOUT_EN
  assign TimedOut  = timed_out_q;
`else
  assign TimedOut  = 1'b0;
`endif

endmodule
